// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Shared CPU definitions used by the fetch sequencer and its neighbours.
//   - fun_sel_e   : address register file function codes (DEC/INC/LOAD/CLR)
//   - reg_sel_e   : address register file enable masks ({PC,SP,AR})
//   - fetch_state_e : state encoding of the instruction fetch sequencer
//   - helpers classifying fetch states (memory read / busy)
// -----------------------------------------------------------------------------
package cpu_defs;

   // Address register file function select
   typedef enum logic [1:0] {
      FUN_DEC  = 2'b00,
      FUN_INC  = 2'b01,
      FUN_LOAD = 2'b10,
      FUN_CLR  = 2'b11
   } fun_sel_e;

   // Address register file enable masks, bit order {PC, SP, AR}
   typedef enum logic [2:0] {
      REG_NONE = 3'b000,
      REG_AR   = 3'b001,
      REG_SP   = 3'b010,
      REG_PC   = 3'b100
   } reg_sel_e;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_LO  = 3'd1,
      ST_INC_LO = 3'd2,
      ST_RD_HI  = 3'd3,
      ST_INC_HI = 3'd4,
      ST_DONE   = 3'd5,
      ST_FAULT  = 3'd6
   } fetch_state_e;

   // States in which the memory read strobe is asserted
   function automatic logic is_read_state(input fetch_state_e s);
      return (s == ST_RD_LO) || (s == ST_RD_HI);
   endfunction

   // States in which the sequencer is working on a fetch
   function automatic logic is_busy_state(input fetch_state_e s);
      return (s == ST_RD_LO) || (s == ST_INC_LO) ||
             (s == ST_RD_HI) || (s == ST_INC_HI);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch sequencer between the address register file (ARF) and a byte-wide
//   memory. It reads two bytes at PC and PC+1, assembles them little-endian
//   into a 16-bit instruction register and steps PC once after each byte by
//   driving the ARF FunSel/RegSel lines. The control unit starts it with
//   fetch_start and watches busy/done/fault.
//
// Parameters
//   TIMEOUT      max cycles to wait for mem_ready per byte; 0 waits forever
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fetch_start  in   request one 16-bit instruction fetch
//   flush        in   synchronous abort of the fetch in progress
//   pc_value     in   current PC (ARF OutC)
//   mem_ready    in   memory data valid this cycle
//   mem_data     in   memory read byte
//   mem_addr     out  memory address (pc_value while reading, else 0)
//   mem_read     out  memory read strobe
//   arf_fun_sel  out  ARF function select
//   arf_reg_sel  out  ARF register enables {PC,SP,AR}
//   ir_out       out  instruction register
//   busy         out  fetch in progress
//   done         out  one-cycle pulse, ir_out holds a new instruction
//   fault        out  memory timeout, held until fetch_start or flush
// -----------------------------------------------------------------------------
module instruction_fetch_unit
   import cpu_defs::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic        flush,
   input  logic [15:0] pc_value,
   input  logic        mem_ready,
   input  logic [7:0]  mem_data,
   output logic [15:0] mem_addr,
   output logic        mem_read,
   output logic [1:0]  arf_fun_sel,
   output logic [2:0]  arf_reg_sel,
   output logic [15:0] ir_out,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   // A zero TIMEOUT still needs a legal (unused) one-bit counter.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   fetch_state_e     state_q, state_d;
   logic [7:0]       lo_byte_q, lo_byte_d;
   logic [15:0]      ir_q, ir_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timed_out;
   logic             abort;

   // Flush aborts everything except a pending fault, which only the
   // control unit's acknowledge (fetch_start or flush) leaves.
   assign abort = flush && (state_q != ST_FAULT);

   // The current read stage has waited its last allowed cycle without data.
   assign timed_out = (TIMEOUT > 0) && !mem_ready && (wait_cnt_q == WAIT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_start) state_d = ST_RD_LO;
            end
            ST_RD_LO: begin
               if (mem_ready)      state_d = ST_INC_LO;
               else if (timed_out) state_d = ST_FAULT;
            end
            ST_INC_LO: begin
               state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
               if (mem_ready)      state_d = ST_INC_HI;
               else if (timed_out) state_d = ST_FAULT;
            end
            ST_INC_HI: begin
               state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d = fetch_start ? ST_RD_LO : ST_IDLE;
            end
            ST_FAULT: begin
               if (fetch_start || flush) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output logic. Flush during an INC stage drops the PC enable in the
   // same cycle so an aborted fetch never moves PC.
   always_comb begin
      mem_read    = 1'b0;
      mem_addr    = 16'h0000;
      arf_fun_sel = FUN_DEC;
      arf_reg_sel = REG_NONE;
      busy        = is_busy_state(state_q);
      done        = (state_q == ST_DONE);
      fault       = (state_q == ST_FAULT);
      if (is_read_state(state_q)) begin
         mem_read = 1'b1;
         mem_addr = pc_value;
      end
      if ((state_q == ST_INC_LO || state_q == ST_INC_HI) && !flush) begin
         arf_fun_sel = FUN_INC;
         arf_reg_sel = REG_PC;
      end
   end

   // Datapath next values. The low byte is staged so the instruction
   // register changes only once, on the high-byte capture. The wait counter
   // is zero outside a stalled read, so each read stage starts from zero.
   always_comb begin
      lo_byte_d  = lo_byte_q;
      ir_d       = ir_q;
      wait_cnt_d = '0;
      if (!abort) begin
         if (state_q == ST_RD_LO && mem_ready) begin
            lo_byte_d = mem_data;
         end
         if (state_q == ST_RD_HI && mem_ready) begin
            ir_d = {mem_data, lo_byte_q};
         end
         if (is_read_state(state_q) && !mem_ready && !timed_out && (TIMEOUT > 0)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_byte_q  <= 8'h00;
         ir_q       <= 16'h0000;
         wait_cnt_q <= '0;
      end else begin
         lo_byte_q  <= lo_byte_d;
         ir_q       <= ir_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign ir_out = ir_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Bench for the fetch sequencer. Surrounds the DUT with a behavioural
//   address register file (PC only) and a 64 KiB byte memory whose ready
//   response is delayed a programmable number of cycles per read. Expected
//   instructions, PC values and completion cycles come from the fetch rules:
//   IR = {mem[PC+1], mem[PC]}, PC += 2, done at cycle 5 + 2*wait_cycles.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_start;
   logic        flush;
   logic [15:0] pc_value;
   logic        mem_ready;
   logic [7:0]  mem_data;
   logic [15:0] mem_addr;
   logic        mem_read;
   logic [1:0]  arf_fun_sel;
   logic [2:0]  arf_reg_sel;
   logic [15:0] ir_out;
   logic        busy;
   logic        done;
   logic        fault;

   logic [7:0]  mem [0:65535];
   logic [15:0] pc_reg;
   logic        pc_load_en;
   logic [15:0] pc_load_val;
   int          ready_delay;
   bit          ready_stuck;
   int          rd_wait;

   int          tests_run;
   int          tests_failed;
   logic [15:0] exp_ir;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_start (fetch_start),
      .flush       (flush),
      .pc_value    (pc_value),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .arf_fun_sel (arf_fun_sel),
      .arf_reg_sel (arf_reg_sel),
      .ir_out      (ir_out),
      .busy        (busy),
      .done        (done),
      .fault       (fault)
   );

   // Memory answers after ready_delay stalled cycles of a read strobe
   assign pc_value  = pc_reg;
   assign mem_data  = mem[mem_addr];
   assign mem_ready = mem_read && !ready_stuck && (rd_wait >= ready_delay);

   // Behavioural ARF (PC only) and memory wait counter
   always @(posedge clk) begin
      if (pc_load_en) begin
         pc_reg <= pc_load_val;
      end else if (arf_reg_sel[2]) begin
         case (arf_fun_sel)
            2'b00:   pc_reg <= pc_reg - 16'd1;
            2'b01:   pc_reg <= pc_reg + 16'd1;
            2'b11:   pc_reg <= 16'h0000;
            default: pc_reg <= pc_reg;
         endcase
      end
      if (!mem_read || mem_ready) rd_wait <= 0;
      else                        rd_wait <= rd_wait + 1;
   end

   // Load PC through the bench ARF; starts and ends on a falling edge
   task automatic set_pc(input logic [15:0] v);
      pc_load_en  = 1'b1;
      pc_load_val = v;
      @(negedge clk);
      pc_load_en  = 1'b0;
   endtask

   // Run one fetch from a falling edge (cycle 0) until done or a bound.
   // With noisy set, fetch_start toggles randomly while the fetch is busy.
   task automatic run_fetch(input int delay, input bit noisy,
                            output int done_cyc, output int inc_cnt,
                            output int read_cnt, output bit addr_ok);
      ready_delay = delay;
      fetch_start = 1'b1;
      done_cyc    = -1;
      inc_cnt     = 0;
      read_cnt    = 0;
      addr_ok     = 1'b1;
      for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         fetch_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (arf_reg_sel == 3'b100 && arf_fun_sel == 2'b01) inc_cnt++;
         if (mem_read) begin
            read_cnt++;
            if (mem_addr !== pc_value) addr_ok = 1'b0;
         end else if (mem_addr !== 16'h0000) begin
            addr_ok = 1'b0;
         end
         if (done) begin
            done_cyc    = cyc;
            fetch_start = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({ir_out, mem_addr, mem_read, arf_fun_sel, arf_reg_sel, busy, done, fault} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got ir=%h addr=%h rd=%b fun=%b sel=%b busy=%b done=%b fault=%b, required all zero",
                  ir_out, mem_addr, mem_read, arf_fun_sel, arf_reg_sel, busy, done, fault);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || mem_read !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_idle: got busy=%b rd=%b, required 0 0", busy, mem_read);
      end
      exp_ir = 16'h0000;
   endtask

   task automatic test_basic;
      int dc, inc, rd;
      bit ok;
      set_pc(16'h0010);
      mem[16'h0010] = 8'h34;
      mem[16'h0011] = 8'h12;
      run_fetch(0, 1'b0, dc, inc, rd, ok);
      exp_ir = 16'h1234;
      tests_run++;
      if (dc !== 5) begin
         tests_failed++;
         $display("[TB] FAIL basic_latency: got cycle %0d, required 5", dc);
      end
      tests_run++;
      if (ir_out !== exp_ir) begin
         tests_failed++;
         $display("[TB] FAIL basic_ir: got %h, required %h", ir_out, exp_ir);
      end
      tests_run++;
      if (pc_reg !== 16'h0012) begin
         tests_failed++;
         $display("[TB] FAIL basic_pc: got %h, required 0012", pc_reg);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b after done cycle, required 0 0", done, busy);
      end
   endtask

   task automatic test_wait_states;
      int dc, inc, rd;
      bit ok;
      set_pc(16'h0100);
      mem[16'h0100] = 8'h5A;
      mem[16'h0101] = 8'hC3;
      run_fetch(3, 1'b0, dc, inc, rd, ok);
      exp_ir = 16'hC35A;
      tests_run++;
      if (dc !== 11) begin
         tests_failed++;
         $display("[TB] FAIL wait_latency: got cycle %0d, required 11", dc);
      end
      tests_run++;
      if (inc !== 2) begin
         tests_failed++;
         $display("[TB] FAIL wait_inc_pulses: got %0d, required 2", inc);
      end
      tests_run++;
      if (rd !== 8 || ok !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL wait_read_hold: got %0d read cycles addr_ok=%b, required 8 and 1", rd, ok);
      end
      tests_run++;
      if (ir_out !== exp_ir || pc_reg !== 16'h0102) begin
         tests_failed++;
         $display("[TB] FAIL wait_result: got ir=%h pc=%h, required %h 0102", ir_out, pc_reg, exp_ir);
      end
   endtask

   task automatic test_wrap;
      int dc, inc, rd;
      bit ok;
      set_pc(16'hFFFF);
      mem[16'hFFFF] = 8'hCD;
      mem[16'h0000] = 8'hAB;
      run_fetch(0, 1'b0, dc, inc, rd, ok);
      exp_ir = 16'hABCD;
      tests_run++;
      if (ir_out !== exp_ir || pc_reg !== 16'h0001) begin
         tests_failed++;
         $display("[TB] FAIL wrap: got ir=%h pc=%h, required %h 0001", ir_out, pc_reg, exp_ir);
      end
   endtask

   task automatic test_timeout;
      int first_fault;
      set_pc(16'h0300);
      mem[16'h0300] = 8'hEE;
      mem[16'h0301] = 8'hFF;
      ready_delay = 0;
      ready_stuck = 1'b0;
      first_fault = -1;
      fetch_start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         fetch_start = 1'b0;
         if (cyc == 2) ready_stuck = 1'b1;
         if (fault && first_fault < 0) first_fault = cyc;
      end
      // High-byte read starts in cycle 3, so the fault appears TIMEOUT later
      tests_run++;
      if (first_fault !== 3 + TIMEOUT) begin
         tests_failed++;
         $display("[TB] FAIL timeout_cycle: got %0d, required %0d", first_fault, 3 + TIMEOUT);
      end
      tests_run++;
      if (fault !== 1'b1 || busy !== 1'b0 || mem_read !== 1'b0 || arf_reg_sel !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL timeout_sticky: got fault=%b busy=%b rd=%b sel=%b, required 1 0 0 000",
                  fault, busy, mem_read, arf_reg_sel);
      end
      tests_run++;
      if (ir_out !== exp_ir || pc_reg !== 16'h0301) begin
         tests_failed++;
         $display("[TB] FAIL timeout_state: got ir=%h pc=%h, required %h 0301", ir_out, pc_reg, exp_ir);
      end
      ready_stuck = 1'b0;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      tests_run++;
      if (fault !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_clear: got fault=%b busy=%b, required 0 0", fault, busy);
      end
   endtask

   task automatic test_flush;
      int inc;
      logic [2:0] sel_seen;
      set_pc(16'h0400);
      mem[16'h0400] = 8'h11;
      mem[16'h0401] = 8'h22;
      ready_delay = 0;
      // Flush together with the low-byte ready
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      inc = 0;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flush_rd_idle: got busy=%b, required 0", busy);
      end
      repeat (3) begin
         if (arf_reg_sel !== 3'b000) inc++;
         @(negedge clk);
      end
      tests_run++;
      if (inc !== 0 || pc_reg !== 16'h0400 || ir_out !== exp_ir) begin
         tests_failed++;
         $display("[TB] FAIL flush_rd_state: got enables=%0d pc=%h ir=%h, required 0 0400 %h", inc, pc_reg, ir_out, exp_ir);
      end
      // Flush during the first PC increment stage
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      #1;
      sel_seen = arf_reg_sel;
      @(negedge clk);
      flush = 1'b0;
      tests_run++;
      if (sel_seen !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL flush_inc_enable: got sel=%b, required 000", sel_seen);
      end
      tests_run++;
      if (busy !== 1'b0 || pc_reg !== 16'h0400 || ir_out !== exp_ir) begin
         tests_failed++;
         $display("[TB] FAIL flush_inc_state: got busy=%b pc=%h ir=%h, required 0 0400 %h", busy, pc_reg, ir_out, exp_ir);
      end
   endtask

   task automatic test_reset_mid;
      set_pc(16'h0500);
      mem[16'h0500] = 8'h77;
      mem[16'h0501] = 8'h66;
      ready_delay = 0;
      fetch_start = 1'b1;
      repeat (4) begin
         @(negedge clk);
         fetch_start = 1'b0;
      end
      tests_run++;
      if (arf_reg_sel !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_inc_hi: got sel=%b, required 100", arf_reg_sel);
      end
      rst_n = 1'b0;
      #1;
      exp_ir = 16'h0000;
      tests_run++;
      if ({ir_out, mem_addr, mem_read, arf_fun_sel, arf_reg_sel, busy, done, fault} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_async: got ir=%h addr=%h rd=%b fun=%b sel=%b busy=%b done=%b fault=%b, required all zero",
                  ir_out, mem_addr, mem_read, arf_fun_sel, arf_reg_sel, busy, done, fault);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (pc_reg !== 16'h0501) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_pc: got %h, required 0501", pc_reg);
      end
   endtask

   task automatic test_back_to_back;
      int first_done, second_done;
      logic busy_after;
      set_pc(16'h0600);
      mem[16'h0600] = 8'h01;
      mem[16'h0601] = 8'h02;
      mem[16'h0602] = 8'h03;
      mem[16'h0603] = 8'h04;
      ready_delay = 0;
      first_done  = -1;
      second_done = -1;
      busy_after  = 1'b0;
      fetch_start = 1'b1;
      for (int cyc = 1; cyc <= 40 && second_done < 0; cyc++) begin
         @(negedge clk);
         if (first_done > 0 && cyc == first_done + 1) begin
            busy_after  = busy && mem_read;
            fetch_start = 1'b0;
         end
         if (done) begin
            if (first_done < 0) first_done  = cyc;
            else                second_done = cyc;
         end
      end
      fetch_start = 1'b0;
      exp_ir = 16'h0403;
      tests_run++;
      if (first_done !== 5 || second_done !== 10) begin
         tests_failed++;
         $display("[TB] FAIL b2b_timing: got done at %0d and %0d, required 5 and 10", first_done, second_done);
      end
      tests_run++;
      if (busy_after !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_no_idle: got busy_read=%b after first done, required 1", busy_after);
      end
      tests_run++;
      if (ir_out !== exp_ir || pc_reg !== 16'h0604) begin
         tests_failed++;
         $display("[TB] FAIL b2b_result: got ir=%h pc=%h, required %h 0604", ir_out, pc_reg, exp_ir);
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      int dc, inc, rd, delay;
      bit ok;
      logic [15:0] pc0, pc1;
      logic [7:0] lo, hi;
      for (int i = 0; i < 16; i++) begin
         pc0   = (i % 5 == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
         pc1   = pc0 + 16'd1;
         lo    = 8'($urandom_range(0, 255));
         hi    = 8'($urandom_range(0, 255));
         delay = $urandom_range(0, TIMEOUT - 1);
         mem[pc0] = lo;
         mem[pc1] = hi;
         set_pc(pc0);
         run_fetch(delay, 1'b1, dc, inc, rd, ok);
         exp_ir = {hi, lo};
         tests_run++;
         if (dc !== 5 + 2 * delay) begin
            tests_failed++;
            $display("[TB] FAIL random_latency[%0d]: got %0d, required %0d", i, dc, 5 + 2 * delay);
         end
         tests_run++;
         if (ir_out !== exp_ir || pc_reg !== pc0 + 16'd2 || ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL random_result[%0d]: got ir=%h pc=%h addr_ok=%b, required %h %h 1",
                     i, ir_out, pc_reg, ok, exp_ir, pc0 + 16'd2);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      fetch_start  = 1'b0;
      flush        = 1'b0;
      pc_load_en   = 1'b0;
      pc_load_val  = 16'h0000;
      ready_delay  = 0;
      ready_stuck  = 1'b0;
      tests_run    = 0;
      tests_failed = 0;
      exp_ir       = 16'h0000;
      @(negedge clk);
      test_reset;
      test_basic;
      test_wait_states;
      test_wrap;
      test_timeout;
      test_flush;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
